// File: rtl/dac_stream_tx.sv
// dac_stream_tx: buffers {A,B} sample pairs in a small FIFO and plays them out
// to a shared parallel DAC bus at a programmable pair rate.
// Optional feature macro: DAC_UNDERRUN_CNT_EN adds a saturating underrun_cnt port.
module dac_stream_tx #(
   parameter int DATA_W     = 14,
   parameter int FIFO_DEPTH = 16,
   parameter int PREFILL    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [7:0]                    div_ratio,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_W-1:0]             s_data_a,
   input  logic [DATA_W-1:0]             s_data_b,
   output logic [DATA_W-1:0]             dac_data,
   output logic                          dac_sel,
   output logic                          dac_wrt,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef DAC_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                   underrun_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREFILL,
      ST_RUN
   } state_e;

   // Pair FIFO storage and pointers
   logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q, level_d;
   logic [2*DATA_W-1:0] rd_pair;
   logic                push, pop, full, empty;

   // Playout control
   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          div_q, div_d;
   logic [7:0]          div_new;
   logic                emit_a, emit_b, urun_d;

   // Output registers
   logic [DATA_W-1:0]   dac_data_q, b_hold_q;
   logic                dac_sel_q, dac_wrt_q, underrun_q;

   assign full    = (level_q == LW'(FIFO_DEPTH));
   assign empty   = (level_q == '0);
   assign push    = s_valid && !full;
   assign rd_pair = mem_q[rd_ptr_q];
   assign div_new = (div_ratio < 8'd2) ? 8'd2 : div_ratio;

   // Level tracks pushes and pops; simultaneous push and pop leaves it unchanged
   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // FIFO payload write (contents need no reset; pointers define validity)
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_data_a, s_data_b};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   // Playout FSM next state, rate counter and emit decisions
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pop     = 1'b0;
      emit_a  = 1'b0;
      emit_b  = 1'b0;
      urun_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (enable) state_d = ST_PREFILL;
         end
         ST_PREFILL: begin
            cnt_d = '0;
            if (!enable)                      state_d = ST_IDLE;
            else if (level_q >= LW'(PREFILL)) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cnt_q == '0) begin
               // Pair boundary: the only place the FSM may leave RUN
               if (!enable) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (empty) begin
                  state_d = ST_PREFILL;
                  urun_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  pop    = 1'b1;
                  emit_a = 1'b1;
                  div_d  = div_new;
                  cnt_d  = 8'd1;
               end
            end else begin
               if (cnt_q == (div_q >> 1)) emit_b = 1'b1;
               cnt_d = (cnt_q == div_q - 8'd1) ? '0 : cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Playout FSM state, rate counter and latched pair period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= 8'd2;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
      end
   end

   // DAC bus register: A on pop, held B on the mid-pair tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_data_q <= '0;
         dac_sel_q  <= 1'b0;
         dac_wrt_q  <= 1'b0;
         underrun_q <= 1'b0;
         b_hold_q   <= '0;
      end else begin
         dac_wrt_q  <= emit_a | emit_b;
         underrun_q <= urun_d;
         if (emit_a) begin
            dac_data_q <= rd_pair[2*DATA_W-1:DATA_W];
            dac_sel_q  <= 1'b0;
            b_hold_q   <= rd_pair[DATA_W-1:0];
         end else if (emit_b) begin
            dac_data_q <= b_hold_q;
            dac_sel_q  <= 1'b1;
         end
      end
   end

`ifdef DAC_UNDERRUN_CNT_EN
   logic [15:0] urun_cnt_q;

   // Saturating starvation counter, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           urun_cnt_q <= '0;
      else if (urun_d && urun_cnt_q != '1)  urun_cnt_q <= urun_cnt_q + 16'd1;
   end

   assign underrun_cnt = urun_cnt_q;
`endif

   assign s_ready    = !full;
   assign fifo_level = level_q;
   assign dac_data   = dac_data_q;
   assign dac_sel    = dac_sel_q;
   assign dac_wrt    = dac_wrt_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_stream_tx.sv
// Self-checking bench for dac_stream_tx: directed corner sequences, a table of
// rate-divider vectors and a randomized run against a pair-order scoreboard.
module tb_dac_stream_tx;

   localparam int DW = 14;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [7:0]    div_ratio;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data_a, s_data_b;
   logic [DW-1:0] dac_data;
   logic          dac_sel, dac_wrt, underrun;
   logic [4:0]    fifo_level;
`ifdef DAC_UNDERRUN_CNT_EN
   logic [15:0]   underrun_cnt;
`endif

   dac_stream_tx #(.DATA_W(DW), .FIFO_DEPTH(16), .PREFILL(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .div_ratio    (div_ratio),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data_a     (s_data_a),
      .s_data_b     (s_data_b),
      .dac_data     (dac_data),
      .dac_sel      (dac_sel),
      .dac_wrt      (dac_wrt),
      .underrun     (underrun),
      .fifo_level   (fifo_level)
`ifdef DAC_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   int last_acc_cyc = 0;

   typedef struct {
      int            cyc;
      logic          sel;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [7:0] div;
      int         period;
      int         half;
   } rate_vec_t;

   wr_t wq[$];
   int  uq[$];

   // Record every bus write and underrun pulse with its cycle stamp
   always @(negedge clk) begin
      wr_t w;
      if (rst_n === 1'b1) begin
         if (dac_wrt) begin
            w.cyc  = cyc;
            w.sel  = dac_sel;
            w.data = dac_data;
            wq.push_back(w);
         end
         if (underrun) uq.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dac_data"}, 32'(dac_data), 32'd0);
      chk({tag, "_dac_sel"}, 32'(dac_sel), 32'd0);
      chk({tag, "_dac_wrt"}, 32'(dac_wrt), 32'd0);
      chk({tag, "_underrun"}, 32'(underrun), 32'd0);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
      chk({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
`ifdef DAC_UNDERRUN_CNT_EN
      chk({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'd0);
`endif
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      enable    = 1'b0;
      s_valid   = 1'b0;
      div_ratio = 8'd4;
      s_data_a  = '0;
      s_data_b  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wq.delete();
      uq.delete();
   endtask

   task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit acc;
      acc      = 1'b0;
      s_valid  = 1'b1;
      s_data_a = a;
      s_data_b = b;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      s_valid      = 1'b0;
      last_acc_cyc = cyc;
      if (!acc) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_wq(input int n, input int budget, input string name);
      for (int i = 0; i < budget && wq.size() < n; i++) begin
         @(negedge clk);
         #1;
      end
      if (wq.size() < n) chk({name, "_timeout"}, 32'(wq.size()), 32'(n));
   endtask

   task automatic push_ramp(input int count, input int base);
      for (int n = 0; n < count; n++)
         push_pair(DW'(base + n), DW'(14'h3FFF - base - n));
   endtask

   rate_vec_t tbl[8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int acc3;
      int nacc;
      bit acc;

      tbl[0] = '{8'd0,   2,   1};
      tbl[1] = '{8'd1,   2,   1};
      tbl[2] = '{8'd2,   2,   1};
      tbl[3] = '{8'd3,   3,   1};
      tbl[4] = '{8'd4,   4,   2};
      tbl[5] = '{8'd5,   5,   2};
      tbl[6] = '{8'd8,   8,   4};
      tbl[7] = '{8'd255, 255, 127};

      // Reset state
      rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; div_ratio = 8'd4;
      s_data_a = '0; s_data_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");

      // Streaming ramp at div 4 with latency check
      do_reset();
      enable = 1'b1;
      acc3 = 0;
      for (int n = 0; n < 10; n++) begin
         push_pair(DW'(n), DW'(14'h3FFF - n));
         if (n == 3) acc3 = last_acc_cyc;
      end
      wait_wq(20, 200, "ramp");
      if (wq.size() >= 20) begin
         chk("ramp_first_latency", 32'(wq[0].cyc), 32'(acc3 + 2));
         for (int i = 0; i < 20; i++) begin
            chk("ramp_data", 32'(wq[i].data),
                (i % 2 == 0) ? 32'(i / 2) : 32'(14'h3FFF - i / 2));
            chk("ramp_sel", 32'(wq[i].sel), 32'(i % 2));
            if (i > 0) chk("ramp_spacing", 32'(wq[i].cyc - wq[i-1].cyc), 32'd2);
         end
      end

      // Asynchronous reset in the middle of playout
      do_reset();
      enable = 1'b1;
      push_ramp(8, 100);
      wait_wq(3, 100, "arst");
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      @(posedge clk);
      #1;

      // Starvation: four pairs, no refill
      do_reset();
      push_ramp(4, 0);
      enable = 1'b1;
      for (int i = 0; i < 100 && uq.size() == 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk("starve_pulses", 32'(uq.size()), 32'd1);
      chk("starve_writes", 32'(wq.size()), 32'd8);
      if (uq.size() > 0 && wq.size() > 0)
         chk("starve_boundary", 32'(uq[0] - wq[0].cyc), 32'd16);
      chk("starve_hold", 32'(dac_data), 32'h3FFC);
      chk("starve_level", 32'(fifo_level), 32'd0);
`ifdef DAC_UNDERRUN_CNT_EN
      chk("starve_cnt", 32'(underrun_cnt), 32'd1);
`endif
      @(negedge clk);
      chk("starve_pulse_width", 32'(underrun), 32'd0);
      @(posedge clk);
      #1;
      push_ramp(4, 4);
      wait_wq(16, 100, "starve_restart");
      if (wq.size() >= 16) chk("starve_restart_data", 32'(wq[8].data), 32'd4);

      // Back-pressure with playout disabled
      do_reset();
      div_ratio = 8'd2;
      nacc = 0;
      for (int k = 0; k < 20; k++) begin
         s_valid  = 1'b1;
         s_data_a = DW'(nacc);
         s_data_b = DW'(nacc + 1000);
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         if (acc) nacc++;
      end
      s_valid = 1'b0;
      chk("bp_accepted", 32'(nacc), 32'd16);
      chk("bp_ready", 32'(s_ready), 32'd0);
      chk("bp_level", 32'(fifo_level), 32'd16);
      enable = 1'b1;
      wait_wq(32, 200, "bp");
      repeat (10) @(negedge clk);
      #1;
      chk("bp_total_writes", 32'(wq.size()), 32'd32);
      for (int k = 0; k < 16 && 2 * k + 1 < wq.size(); k++) begin
         chk("bp_a", 32'(wq[2*k].data), 32'(k));
         chk("bp_b", 32'(wq[2*k+1].data), 32'(k + 1000));
      end

      // Rate table: pair period and A-to-B offset per div_ratio
      for (int t = 0; t < 8; t++) begin
         do_reset();
         div_ratio = tbl[t].div;
         push_ramp(4, 0);
         enable = 1'b1;
         wait_wq(3, 700, "rate");
         if (wq.size() >= 3) begin
            chk("rate_half", 32'(wq[1].cyc - wq[0].cyc), 32'(tbl[t].half));
            chk("rate_period", 32'(wq[2].cyc - wq[0].cyc), 32'(tbl[t].period));
         end
      end

      // div_ratio change 4 -> 8 in the middle of a pair
      do_reset();
      push_ramp(4, 0);
      enable = 1'b1;
      wait_wq(1, 50, "midchg");
      div_ratio = 8'd8;
      wait_wq(5, 100, "midchg");
      if (wq.size() >= 5) begin
         chk("midchg_b0", 32'(wq[1].cyc - wq[0].cyc), 32'd2);
         chk("midchg_a1", 32'(wq[2].cyc - wq[0].cyc), 32'd4);
         chk("midchg_b1", 32'(wq[3].cyc - wq[2].cyc), 32'd4);
         chk("midchg_a2", 32'(wq[4].cyc - wq[2].cyc), 32'd8);
      end

      // Enable dropped just after a pop at D=8
      do_reset();
      div_ratio = 8'd8;
      push_ramp(6, 0);
      enable = 1'b1;
      wait_wq(1, 50, "endrop");
      enable = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      chk("endrop_writes", 32'(wq.size()), 32'd2);
      if (wq.size() >= 2) begin
         chk("endrop_b_gap", 32'(wq[1].cyc - wq[0].cyc), 32'd4);
         chk("endrop_b_sel", 32'(wq[1].sel), 32'd1);
         chk("endrop_b_data", 32'(wq[1].data), 32'h3FFF);
      end
      chk("endrop_level", 32'(fifo_level), 32'd5);
      chk("endrop_no_underrun", 32'(uq.size()), 32'd0);

      // Randomized run against a pair-order scoreboard
      begin
         logic [2*DW-1:0] mq[$];
         logic [2*DW-1:0] exp_pair;
         logic [DW-1:0]   pend_b;
         bit              have_b, have_a, last_acc;
         int              acc_tot, pop_tot, model_lvl;
         int              cur_d, last_a_cyc, div_at_edge, p_valid;

         do_reset();
         enable = 1'b1;
         have_b = 0; have_a = 0; last_acc = 0;
         acc_tot = 0; pop_tot = 0; cur_d = 2; last_a_cyc = 0;
         div_at_edge = int'(div_ratio);
         p_valid = 50;
         pend_b = '0;
         for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
               case ($urandom_range(0, 2))
                  0:       p_valid = 20;
                  1:       p_valid = 50;
                  default: p_valid = 95;
               endcase
            end
            s_valid  = ($urandom_range(0, 99) < p_valid);
            s_data_a = DW'($urandom);
            s_data_b = DW'($urandom);
            if ($urandom_range(0, 49) == 0) div_ratio = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            @(negedge clk);
            if (dac_wrt) begin
               if (!dac_sel) begin
                  chk("rnd_b_skipped", 32'(have_b), 32'd0);
                  if (mq.size() == 0) begin
                     chk("rnd_unexpected_a", 32'd1, 32'd0);
                  end else begin
                     exp_pair = mq.pop_front();
                     chk("rnd_a_data", 32'(dac_data), 32'(exp_pair[2*DW-1:DW]));
                     pend_b = exp_pair[DW-1:0];
                     have_b = 1;
                  end
                  if (have_a) chk("rnd_a_spacing", 32'((cyc - last_a_cyc) >= cur_d), 32'd1);
                  cur_d      = (div_at_edge < 2) ? 2 : div_at_edge;
                  last_a_cyc = cyc;
                  have_a     = 1;
                  pop_tot++;
               end else begin
                  chk("rnd_b_pending", 32'(have_b), 32'd1);
                  chk("rnd_b_data", 32'(dac_data), 32'(pend_b));
                  chk("rnd_b_gap", 32'(cyc - last_a_cyc), 32'(cur_d / 2));
                  have_b = 0;
               end
            end
            model_lvl = acc_tot - pop_tot;
            chk("rnd_level", 32'(fifo_level), 32'(model_lvl));
            chk("rnd_ready", 32'(s_ready), 32'(model_lvl < 16));
            if (underrun) begin
               chk("rnd_underrun_not_empty", 32'(model_lvl), 32'(last_acc));
               chk("rnd_underrun_mid_pair", 32'(have_b), 32'd0);
            end
            last_acc = s_valid && s_ready;
            if (last_acc) begin
               mq.push_back({s_data_a, s_data_b});
               acc_tot++;
            end
            div_at_edge = int'(div_ratio);
            @(posedge clk);
            #1;
         end
         s_valid = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
